// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell plus a carry flip-flop,
// consuming one operand bit per clock, LSB first, framed by start/busy/done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    bit_cnt;
    logic             carry;

    logic             bit_sum;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;

    // The single full-add cell working on the current LSBs and the stored carry
    assign bit_sum    = a_reg[0] ^ b_reg[0] ^ carry;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign res_next   = {bit_sum, res_reg[WIDTH-1:1]};

    // Handshake FSM, operand/result shifting and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        res_reg <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= res_next;
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= carry_next;
                        ovf   <= carry ^ carry_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for directed and
// randomized runs, and a 4-bit instance swept exhaustively.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
    logic       ovf4;

    int         n_checks;
    int         n_pass;
    int         n_fail;
    logic [7:0] last_sum;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit addition checked against plain integer arithmetic.
    // Begins in any cycle where the DUT can accept (idle or done) and ends in its done cycle.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                  input bit keep_start, input bit disturb);
        int   exact;
        logic exp_ovf;
        exact   = int'(av) + int'(bv) + int'(cv);
        exp_ovf = (av[7] == bv[7]) && (exact[7] != av[7]);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        tick();
        if (!keep_start) start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("busy_run", 32'(busy), 32'(1'b1));
            check_val("done_run", 32'(done), 32'(1'b0));
            check_val("sum_hold", 32'(sum), 32'(last_sum));
            if (disturb && i == 3) begin
                start = 1'b1;
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = ~cv;
            end else if (disturb && i == 4) begin
                start = 1'b0;
            end
            if (keep_start) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            tick();
        end
        check_output(8'(exact), exact[8], exp_ovf);
        last_sum = 8'(exact);
    endtask

    task automatic check_output(input logic [7:0] es, input logic ec, input logic eo);
        check_val("done_pulse", 32'(done), 32'(1'b1));
        check_val("busy_done", 32'(busy), 32'(1'b0));
        check_val("sum", 32'(sum), 32'(es));
        check_val("cout", 32'(cout), 32'(ec));
        check_val("ovf", 32'(ovf), 32'(eo));
    endtask

    // One 4-bit addition on the small instance, also checking the subtract round trip
    task automatic apply_stimulus4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        int   exact;
        logic exp_ovf;
        exact   = int'(av) + int'(bv) + int'(cv);
        exp_ovf = (av[3] == bv[3]) && (exact[3] != av[3]);
        start4 = 1'b1;
        a4     = av;
        b4     = bv;
        cin4   = cv;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("w4_busy", 32'(busy4), 32'(1'b1));
            tick();
        end
        check_val("w4_done", 32'(done4), 32'(1'b1));
        check_val("w4_cout_sum", 32'({cout4, sum4}), 32'(exact));
        check_val("w4_ovf", 32'(ovf4), 32'(exp_ovf));
        check_val("w4_sub_back", 32'(4'(sum4 - bv - 4'(cv))), 32'(av));
    endtask

    initial begin
        int idle_done;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        last_sum = 8'h00;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        start4   = 1'b0;
        a4       = 4'h0;
        b4       = 4'h0;
        cin4     = 1'b0;
        $display("[TB] starting serial_adder bench");

        // Reset state
        repeat (3) tick();
        check_val("rst_busy", 32'(busy), 32'(1'b0));
        check_val("rst_done", 32'(done), 32'(1'b0));
        check_val("rst_sum", 32'(sum), 32'(8'h00));
        check_val("rst_cout", 32'(cout), 32'(1'b0));
        check_val("rst_ovf", 32'(ovf), 32'(1'b0));
        check_val("rst_busy4", 32'(busy4), 32'(1'b0));
        rst_n = 1'b1;
        tick();

        // Directed corner cases
        apply_stimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("idle_done", 32'(done), 32'(1'b0));
        check_val("idle_busy", 32'(busy), 32'(1'b0));
        check_val("idle_sum_hold", 32'(sum), 32'(8'h96));
        apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();

        // Randomized operands
        repeat (12) begin
            apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
            if ($urandom_range(1, 0) == 1) tick();
        end

        // Start pulse and operand changes mid-run must be ignored
        apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
        tick();
        check_val("single_done", 32'(done), 32'(1'b0));
        check_val("no_restart", 32'(busy), 32'(1'b0));

        // Reset in the middle of an operation aborts it
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_val("abort_busy", 32'(busy), 32'(1'b0));
        check_val("abort_done", 32'(done), 32'(1'b0));
        check_val("abort_sum", 32'(sum), 32'(8'h00));
        check_val("abort_cout", 32'(cout), 32'(1'b0));
        check_val("abort_ovf", 32'(ovf), 32'(1'b0));
        rst_n     = 1'b1;
        last_sum  = 8'h00;
        idle_done = 0;
        repeat (10) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) idle_done++;
        end
        check_val("abort_no_done", 32'(idle_done), 32'(0));
        apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);

        // Back-to-back runs with start held high
        tick();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        start = 1'b0;
        tick();
        check_val("b2b_end_done", 32'(done), 32'(1'b0));

        // Exhaustive sweep of the 4-bit instance
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    apply_stimulus4(4'(av), 4'(bv), 1'(cv));
                end
            end
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit binary adder: the additive counterpart to the team's full_subtract and half_subtract blocks. It reuses a single full-add cell and a carry flip-flop, and processes one operand bit per clock, LSB first. A start/busy/done handshake frames each operation. The block serves as the area-minimal arithmetic unit in the training designs, and is the golden partner for checking subtractor results (A - B + B == A).

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
start  input  1  request a new addition; sampled only when not busy
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  A + B + cin, modulo 2^WIDTH
cout  output  1  carry out of the MSB
ovf  output  1  signed (two's complement) overflow: carry into MSB XOR cout

Behaviour:
- Reset (rst_n low at a rising edge): state goes to IDLE.
  - busy, done, sum, cout, ovf all become 0.
  - Internal shift registers, bit counter and carry flip-flop are cleared.
  - Reset has priority over start and over any operation in progress.
  - Reset mid-RUN aborts the operation; no done pulse is generated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches a, b and cin, loads the bit counter with 0, and moves to RUN.
  - start=0 holds IDLE.
- RUN, one bit per clock:
  - bit i = a_reg[0] ^ b_reg[0] ^ c.
  - New c = majority(a_reg[0], b_reg[0], c).
  - The bit shifts into the MSB of the result shift register; a_reg and b_reg shift right.
  - The counter increments each clock.
  - After the edge that processes bit WIDTH-1, the state moves to DONE.
  - At that same edge, sum, cout and ovf are loaded from the result register, the final carry and (carry-in to MSB ^ final carry).
  - start is ignored in RUN; operands already latched are unaffected.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 at the DONE edge is accepted exactly as in IDLE, going directly to RUN. This allows back-to-back operations with no idle cycle.
  - Otherwise the state returns to IDLE.
- busy is 1 exactly in RUN.
- Latency:
  - Start sampled at edge k.
  - busy is high for cycles k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- sum, cout and ovf hold the last completed result until the next completion or reset. They never show partial values.
- Arithmetic is unsigned modulo 2^WIDTH. The pair {cout, sum} equals the exact WIDTH+1-bit unsigned sum.
- cin=1 with both operands 0 gives sum=1.
- Operand changes on a and b after the accepting edge have no effect.

Test Plan:
1. WIDTH=8, start with a=0x5A, b=0x3C, cin=0 -> after 8 busy cycles: done pulse, sum=0x96, cout=0, ovf=1 (90+60 exceeds +127).
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Separately, a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. Separately, a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Start accepted, then start pulsed and a/b changed mid-RUN -> busy length stays 8, a single done pulse, result matches originally latched operands.
4. rst_n driven low during bit 4 of an operation -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, no done pulse. A subsequent start runs correctly.
5. start held high continuously with new operands presented each DONE cycle -> done pulses every 9 cycles, each result correct, no idle cycle between runs.
6. Exhaustive cross-check at WIDTH=4: all a, b in 0..15 and cin in {0,1} -> {cout,sum} == a+b+cin. ovf matches the signed-range check. Results are consistent with full_subtract: (a+b) - b == a mod 16.
